// File: rtl/roll_controller.sv
// Die-roll sequencer: fetches entropy, rejection-samples it against the die's limit,
// reduces the accepted byte with a restoring divider, and streams raw bytes in test mode.
module roll_controller #(
  parameter int MAX_TRIES  = 16,
  parameter int STREAM_LEN = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_roll_req,
  input  logic [2:0] i_die_sel,
  output logic       o_rand_req,
  input  logic       i_rand_valid,
  input  logic [7:0] i_rand_data,
  output logic       o_busy,
  output logic       o_result_valid,
  output logic [4:0] o_result,
  output logic       o_error,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_ready
);

  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int SW = $clog2(STREAM_LEN + 1);
  localparam logic [TW-1:0] TRY_LAST  = TW'(MAX_TRIES - 1);
  localparam logic [SW-1:0] SEND_LAST = SW'(STREAM_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CHECK,
    ST_REDUCE,
    ST_DONE,
    ST_SFETCH,
    ST_SSEND
  } state_t;

  state_t        r_state;
  logic [4:0]    r_sides;
  logic [8:0]    r_limit;
  logic          r_stream;
  logic          r_err;
  logic [7:0]    r_byte;
  logic [7:0]    r_shift;
  logic [7:0]    r_rem;
  logic [2:0]    r_bit;
  logic [TW-1:0] r_tries;
  logic [SW-1:0] r_sent;

  logic [4:0]    w_sides;
  logic [8:0]    w_limit;
  logic          w_sel_ok;
  logic [8:0]    w_trial;
  logic          w_ge;
  logic [7:0]    w_rem_next;
  logic          w_reject;
  logic [4:0]    w_face;

  // Limit L is the largest multiple of N that fits in 256, so B < L is bias-free.
  always_comb begin
    w_sides  = 5'd0;
    w_limit  = 9'd0;
    w_sel_ok = 1'b0;
    case (i_die_sel)
      3'd0: begin w_sides = 5'd4;  w_limit = 9'd256; w_sel_ok = 1'b1; end
      3'd1: begin w_sides = 5'd6;  w_limit = 9'd252; w_sel_ok = 1'b1; end
      3'd2: begin w_sides = 5'd8;  w_limit = 9'd256; w_sel_ok = 1'b1; end
      3'd3: begin w_sides = 5'd10; w_limit = 9'd250; w_sel_ok = 1'b1; end
      3'd4: begin w_sides = 5'd12; w_limit = 9'd252; w_sel_ok = 1'b1; end
      3'd5: begin w_sides = 5'd20; w_limit = 9'd240; w_sel_ok = 1'b1; end
      default: ;
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, subtract N when it fits.
  assign w_trial    = {r_rem, r_shift[7]};
  assign w_ge       = (w_trial >= {4'd0, r_sides});
  assign w_rem_next = w_ge ? 8'(w_trial - {4'd0, r_sides}) : w_trial[7:0];
  assign w_reject   = ({1'b0, r_byte} >= r_limit);
  assign w_face     = r_rem[4:0] + 5'd1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_sides        <= 5'd0;
      r_limit        <= 9'd0;
      r_stream       <= 1'b0;
      r_err          <= 1'b0;
      r_byte         <= 8'd0;
      r_shift        <= 8'd0;
      r_rem          <= 8'd0;
      r_bit          <= 3'd0;
      r_tries        <= '0;
      r_sent         <= '0;
      o_rand_req     <= 1'b0;
      o_busy         <= 1'b0;
      o_result_valid <= 1'b0;
      o_result       <= 5'd0;
      o_error        <= 1'b0;
      o_tx_valid     <= 1'b0;
      o_tx_data      <= 8'd0;
    end else begin
      o_result_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_roll_req) begin
            r_sides  <= w_sides;
            r_limit  <= w_limit;
            r_tries  <= '0;
            r_sent   <= '0;
            r_stream <= (i_die_sel == 3'd7);
            o_busy   <= 1'b1;
            if (i_die_sel == 3'd7) begin
              r_err      <= 1'b0;
              o_rand_req <= 1'b1;
              r_state    <= ST_SFETCH;
            end else if (w_sel_ok) begin
              r_err      <= 1'b0;
              o_rand_req <= 1'b1;
              r_state    <= ST_FETCH;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end

        ST_FETCH: begin
          if (i_rand_valid) begin
            r_byte     <= i_rand_data;
            o_rand_req <= 1'b0;
            r_state    <= ST_CHECK;
          end
        end

        ST_CHECK: begin
          if (w_reject) begin
            if (r_tries == TRY_LAST) begin
              r_tries <= '0;
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_tries    <= r_tries + TW'(1);
              o_rand_req <= 1'b1;
              r_state    <= ST_FETCH;
            end
          end else begin
            r_tries <= '0;
            r_rem   <= 8'd0;
            r_shift <= r_byte;
            r_bit   <= 3'd0;
            r_state <= ST_REDUCE;
          end
        end

        ST_REDUCE: begin
          r_rem   <= w_rem_next;
          r_shift <= {r_shift[6:0], 1'b0};
          r_bit   <= r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            r_state <= ST_DONE;
          end
        end

        // Result and error hold after the pulse until the next roll completes.
        ST_DONE: begin
          o_result_valid <= 1'b1;
          o_busy         <= 1'b0;
          r_state        <= ST_IDLE;
          if (r_err) begin
            o_result <= 5'd0;
            o_error  <= 1'b1;
          end else if (r_stream) begin
            o_result <= 5'd0;
            o_error  <= 1'b0;
          end else begin
            o_result <= w_face;
            o_error  <= 1'b0;
          end
        end

        ST_SFETCH: begin
          if (i_rand_valid) begin
            o_tx_data  <= i_rand_data;
            o_rand_req <= 1'b0;
            o_tx_valid <= 1'b1;
            r_state    <= ST_SSEND;
          end
        end

        ST_SSEND: begin
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            if (r_sent == SEND_LAST) begin
              r_sent  <= '0;
              r_state <= ST_DONE;
            end else begin
              r_sent     <= r_sent + SW'(1);
              o_rand_req <= 1'b1;
              r_state    <= ST_SFETCH;
            end
          end
        end

        default: begin
          o_rand_req <= 1'b0;
          o_tx_valid <= 1'b0;
          o_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_roll_controller.sv
// Self-checking bench for roll_controller: a transaction-level model predicts every
// cycle's outputs from the die rules, and directed rolls pin literal results.
module tb_roll_controller;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_roll_req;
  logic [2:0] i_die_sel;
  logic       o_rand_req;
  logic       i_rand_valid;
  logic [7:0] i_rand_data;
  logic       o_busy;
  logic       o_result_valid;
  logic [4:0] o_result;
  logic       o_error;
  logic       o_tx_valid;
  logic [7:0] o_tx_data;
  logic       i_tx_ready;

  always #5 i_clk = ~i_clk;

  roll_controller #(.MAX_TRIES(16), .STREAM_LEN(16)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_roll_req    (i_roll_req),
    .i_die_sel     (i_die_sel),
    .o_rand_req    (o_rand_req),
    .i_rand_valid  (i_rand_valid),
    .i_rand_data   (i_rand_data),
    .o_busy        (o_busy),
    .o_result_valid(o_result_valid),
    .o_result      (o_result),
    .o_error       (o_error),
    .o_tx_valid    (o_tx_valid),
    .o_tx_data     (o_tx_data),
    .i_tx_ready    (i_tx_ready)
  );

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;
  bit checkEn     = 0;

  always @(posedge i_clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Model: die rules expressed as sides table, bias-free limit and latency counts.
  int sidesTab[6] = '{4, 6, 8, 10, 12, 20};
  bit mBusy, mFetch, mSend, mRefetch, mStream;
  int mCount, mTries, mSent, mN, mL, mPendRes, mPendErr, mTxData, b;
  bit expValid;
  int expResult, expError;

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mBusy = 0; mFetch = 0; mSend = 0; mRefetch = 0; mStream = 0;
      mCount = 0; mTries = 0; mSent = 0; mN = 0; mL = 0;
      mPendRes = 0; mPendErr = 0; mTxData = 0;
      expValid = 0; expResult = 0; expError = 0;
    end else begin
      expValid = 0;
      if (!mBusy) begin
        if (i_roll_req) begin
          mBusy = 1; mTries = 0; mSent = 0; mStream = 0;
          if (i_die_sel <= 3'd5) begin
            mN = sidesTab[i_die_sel];
            mL = 256 - (256 % mN);
            mFetch = 1;
          end else if (i_die_sel == 3'd6) begin
            mPendRes = 0; mPendErr = 1; mCount = 1;
          end else begin
            mStream = 1; mFetch = 1;
          end
        end
      end else if (mCount > 0) begin
        mCount--;
        if (mCount == 0) begin
          expValid = 1; expResult = mPendRes; expError = mPendErr; mBusy = 0;
        end
      end else if (mRefetch) begin
        mRefetch = 0; mFetch = 1;
      end else if (mFetch) begin
        if (i_rand_valid) begin
          mFetch = 0;
          b = int'(i_rand_data);
          if (mStream) begin
            mTxData = b; mSend = 1;
          end else if (b < mL) begin
            mPendRes = b % mN + 1; mPendErr = 0; mCount = 10;
          end else begin
            mTries++;
            if (mTries == 16) begin
              mPendRes = 0; mPendErr = 1; mCount = 2;
            end else begin
              mRefetch = 1;
            end
          end
        end
      end else if (mSend) begin
        if (i_tx_ready) begin
          mSend = 0; mSent++;
          if (mSent == 16) begin
            mPendRes = 0; mPendErr = 0; mCount = 1;
          end else begin
            mFetch = 1;
          end
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge i_clk) begin
    if (checkEn && !i_reset) begin
      checkOutput("busy", o_busy, mBusy);
      checkOutput("rand_req", o_rand_req, mFetch);
      checkOutput("tx_valid", o_tx_valid, mSend);
      checkOutput("result_valid", o_result_valid, expValid);
      checkOutput("result", o_result, expResult);
      checkOutput("error", o_error, expError);
      checkOutput("req_tx_exclusive", o_rand_req & o_tx_valid, 0);
      if (mSend) checkOutput("tx_data", o_tx_data, mTxData);
    end
  end

  task automatic applyStimulus(input logic [2:0] sel);
    i_die_sel  = sel;
    i_roll_req = 1'b1;
    @(negedge i_clk);
    i_roll_req = 1'b0;
  endtask

  task automatic giveByte(input logic [7:0] data, output int capCyc);
    int n = 0;
    while (!o_rand_req && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_rand_req) checkOutput("rand_req_timeout", o_rand_req, 1);
    i_rand_valid = 1'b1;
    i_rand_data  = data;
    @(negedge i_clk);
    capCyc       = cyc;
    i_rand_valid = 1'b0;
    i_rand_data  = 8'h00;
  endtask

  task automatic waitResult(output int atCyc, output logic [4:0] res, output logic err);
    int n = 0;
    while (!o_result_valid && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_result_valid) checkOutput("result_timeout", o_result_valid, 1);
    atCyc = cyc;
    res   = o_result;
    err   = o_error;
    @(negedge i_clk);
  endtask

  task automatic rollOne(input string name, input logic [2:0] sel, input logic [7:0] data,
                         input int expRes);
    int cap, at;
    logic [4:0] res;
    logic err;
    applyStimulus(sel);
    giveByte(data, cap);
    waitResult(at, res, err);
    checkOutput({name, "_latency"}, at - cap, 10);
    checkOutput({name, "_result"}, res, expRes);
    checkOutput({name, "_error"}, err, 0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cap, at, c0, extra, phase, n;
    logic [4:0] res;
    logic err;
    logic [7:0] got[$];

    i_reset = 1'b1; i_roll_req = 1'b0; i_die_sel = 3'd0;
    i_rand_valid = 1'b0; i_rand_data = 8'h00; i_tx_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("reset_busy", o_busy, 0);
    checkOutput("reset_rand_req", o_rand_req, 0);
    checkOutput("reset_result_valid", o_result_valid, 0);
    checkOutput("reset_tx_valid", o_tx_valid, 0);
    checkOutput("reset_result", o_result, 0);
    i_reset = 1'b0;
    checkEn = 1;
    @(negedge i_clk);

    $display("[TB] d6 roll, byte 0x2B");
    rollOne("d6_2B", 3'd1, 8'h2B, 2);

    $display("[TB] d20 rejection then accept");
    applyStimulus(3'd5);
    giveByte(8'hF5, cap);
    giveByte(8'h13, cap);
    waitResult(at, res, err);
    checkOutput("d20_13_latency", at - cap, 10);
    checkOutput("d20_13_result", res, 20);
    applyStimulus(3'd5);
    giveByte(8'hF0, cap);
    giveByte(8'hEF, cap);
    waitResult(at, res, err);
    checkOutput("d20_EF_result", res, 20);
    checkOutput("d20_EF_error", err, 0);

    $display("[TB] d10 exhaustion");
    applyStimulus(3'd3);
    for (int i = 0; i < 16; i++) giveByte(8'hFF, cap);
    waitResult(at, res, err);
    checkOutput("exhaust_latency", at - cap, 2);
    checkOutput("exhaust_result", res, 0);
    checkOutput("exhaust_error", err, 1);

    $display("[TB] invalid select");
    c0 = cyc;
    applyStimulus(3'd6);
    waitResult(at, res, err);
    checkOutput("invalid_latency", at - c0, 2);
    checkOutput("invalid_error", err, 1);

    $display("[TB] test stream");
    applyStimulus(3'd7);
    phase = 0;
    for (int i = 0; i < 16; i++) begin
      giveByte(8'(i), cap);
      n = 0;
      while (n < 20) begin
        phase++;
        i_tx_ready = (phase % 3 == 0);
        if (i_tx_ready && o_tx_valid) begin
          got.push_back(o_tx_data);
          @(negedge i_clk);
          break;
        end
        @(negedge i_clk);
        n++;
      end
      i_tx_ready = 1'b0;
    end
    waitResult(at, res, err);
    checkOutput("stream_result", res, 0);
    checkOutput("stream_error", err, 0);
    checkOutput("stream_count", got.size(), 16);
    for (int i = 0; i < got.size(); i++) checkOutput("stream_order", got[i], i);

    $display("[TB] busy roll_req ignored, then reset mid-reduce");
    applyStimulus(3'd1);
    giveByte(8'h2B, cap);
    repeat (3) @(negedge i_clk);
    applyStimulus(3'd0);
    waitResult(at, res, err);
    checkOutput("busy_result", res, 2);
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      if (o_result_valid) extra++;
      @(negedge i_clk);
    end
    checkOutput("busy_single_result", extra, 0);
    applyStimulus(3'd2);
    giveByte(8'h05, cap);
    repeat (4) @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_result", o_result, 0);
    checkOutput("rst_result_valid", o_result_valid, 0);
    checkOutput("rst_rand_req", o_rand_req, 0);
    checkOutput("rst_tx_valid", o_tx_valid, 0);
    checkOutput("rst_tx_data", o_tx_data, 0);
    @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    rollOne("after_rst_d8_FF", 3'd2, 8'hFF, 8);

    $display("[TB] d4/d8 full range");
    rollOne("d4_00", 3'd0, 8'h00, 1);
    rollOne("d4_FF", 3'd0, 8'hFF, 4);
    rollOne("d8_00", 3'd2, 8'h00, 1);
    rollOne("d12_C8", 3'd4, 8'hC8, 9);

    repeat (5) @(negedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/roll_controller.md
Name: roll_controller

Overview:
- Sequences one die roll end to end:
  - Requests random bytes from the entropy source.
  - Rejection-samples them to remove modulo bias.
  - Reduces the accepted byte to a 1-based face value with a multi-cycle restoring divider.
- Also provides a test mode that streams raw entropy bytes to the UART transmitter through a valid/ready handshake.
- Sits between the user-input decode, the entropy source and the display/UART path.

Parameters:
- MAX_TRIES, 16: consecutive rejected bytes allowed before a roll aborts with error.
- STREAM_LEN, 16: number of raw bytes forwarded per test-mode request.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  asynchronous, active-high reset
- i_roll_req  input  1  single-cycle roll request; sampled only in IDLE
- i_die_sel  input  3  0=d4, 1=d6, 2=d8, 3=d10, 4=d12, 5=d20, 6=invalid, 7=test stream
- o_rand_req  output  1  high while waiting for an entropy byte
- i_rand_valid  input  1  entropy byte present; consumed in the same cycle while o_rand_req=1
- i_rand_data  input  8  entropy byte
- o_busy  output  1  high in every state except IDLE
- o_result_valid  output  1  one-cycle pulse, result/error valid
- o_result  output  5  face value 1..20; 0 on error
- o_error  output  1  qualifies o_result_valid: invalid select or MAX_TRIES exhausted
- o_tx_valid  output  1  test-mode byte available
- o_tx_data  output  8  test-mode byte
- i_tx_ready  input  1  UART transmitter accepts the byte when o_tx_valid & i_tx_ready

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0, including o_result, o_tx_data and o_busy. Try and stream counters 0.
- All outputs are registered.
- IDLE:
  - On i_roll_req=1, latch i_die_sel into sides N and acceptance limit L.
  - Limits: d4 N=4 L=256; d6 N=6 L=252; d8 N=8 L=256; d10 N=10 L=250; d12 N=12 L=252; d20 N=20 L=240.
  - sel 0-5 -> FETCH; sel 6 -> DONE with error; sel 7 -> S_FETCH.
- FETCH: o_rand_req=1. When i_rand_valid=1, capture the byte B and go to CHECK. Waits indefinitely otherwise.
- CHECK (1 cycle):
  - If B >= L (9-bit compare): increment tries. If tries reaches MAX_TRIES -> DONE with error; else -> FETCH.
  - If B < L -> REDUCE, tries cleared.
- REDUCE:
  - Exactly 8 cycles, one quotient bit per cycle, MSB first.
  - 9-bit partial remainder: shift in the next bit of B; subtract N if the partial remainder >= N.
  - Final remainder R = B mod N, range 0..N-1.
- DONE (1 cycle):
  - o_result_valid=1. o_result = R+1 (5-bit, max 20), o_error=0; on error o_result=0, o_error=1.
  - o_result/o_error hold until the next DONE or reset. Next state IDLE.
- Latency: byte capture edge -> o_result_valid high 10 cycles later (CHECK 1 + REDUCE 8 + DONE 1), per accepted byte.
- Test stream:
  - S_FETCH: o_rand_req=1; on i_rand_valid, load o_tx_data=byte -> S_SEND.
  - S_SEND: o_tx_valid=1, o_tx_data stable until i_tx_ready=1. On the handshake, count++. If count==STREAM_LEN -> DONE (o_result=0, o_error=0) -> IDLE; else -> S_FETCH.
- i_roll_req or a i_die_sel change while o_busy=1: ignored, with no queuing.
- o_rand_req and o_tx_valid are never high in the same cycle.
- Reset mid-REDUCE or mid-S_SEND: immediate return to IDLE with o_tx_valid=0. A partial stream is discarded, not resumed.

Test Plan:
- d6 roll: sel=1, roll_req pulse, rand byte 0x2B (43) -> one CHECK, 8 REDUCE cycles, o_result_valid pulse 10 cycles after capture with o_result=2, o_error=0.
- d20 rejection: bytes 0xF5 (245) then 0x13 (19) -> first byte rejected, o_rand_req reasserts, second byte gives o_result=20. Boundary: 0xEF (239) accepted -> o_result=20; 0xF0 (240) rejected.
- Exhaustion: d10 with entropy always 0xFF -> exactly 16 fetches, then o_result_valid=1, o_error=1, o_result=0. Invalid sel=6 -> error pulse 2 cycles after roll_req, with no o_rand_req.
- Test stream: sel=7, entropy 0x00..0x0F, i_tx_ready toggling 1-of-3 cycles -> 16 bytes delivered in order, o_tx_data stable while stalled, then o_result_valid with o_error=0.
- Busy/reset: roll_req pulsed during REDUCE is ignored (single result). Then i_reset asserted mid-REDUCE -> all outputs 0 the same cycle, IDLE, and the next roll completes normally.
- d4/d8 full range: bytes 0x00 and 0xFF -> results 1 and 4 (d4), 1 and 8 (d8), with no rejections.
